// File: rtl/iob_2p_mem_be.sv
// Simple dual-port RAM: one write port and one read port on a single clock.
// The write port has byte-lane strobes. Read latency is 1 or 2 cycles, with
// a one-cycle r_valid pulse. A same-address collision returns either the
// merged new word (BYPASS=1) or the old word (BYPASS=0).
// data_out holds the last read result until the next r_valid.
module iob_2p_mem_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  r_en,
    input  logic [ADDR_W-1:0]     r_addr,
    output logic [DATA_W-1:0]     data_out,
    output logic                  r_valid
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    // Reject configurations that the byte lanes or the read pipeline cannot support.
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("iob_2p_mem_be: DATA_W must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("iob_2p_mem_be: RD_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] w_rd_old;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_hit;
    logic              w_bypass;
    logic [DATA_W-1:0] r_dout;
    logic              r_vld;

    // The array has no reset. Writes are held off while the reset is asserted.
    always_ff @(posedge clk) begin
        if (w_en && !rst) begin
            for (int i = 0; i < NB; i++) begin
                if (w_strb[i]) begin
                    r_mem[w_addr][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    assign w_rd_old = r_mem[r_addr];
    assign w_hit    = w_en && r_en && (w_addr == r_addr);
    assign w_bypass = (BYPASS != 0) && w_hit;

    // On a write-first collision, the strobed lanes take the incoming data.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign w_rd_word[8*gi +: 8] = (w_bypass && w_strb[gi]) ? data_in[8*gi +: 8]
                                                               : w_rd_old[8*gi +: 8];
    end

    if (RD_LAT == 1) begin : g_lat1
        // Single stage: the issued word lands directly in the output register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_vld <= r_en;
                if (r_en) begin
                    r_dout <= w_rd_word;
                end
            end
        end
    end else begin : g_lat2
        logic [DATA_W-1:0] r_s1_data;
        logic              r_s1_vld;

        // Stage 1 data: the value is fixed at the issue edge.
        // A later write does not change it.
        always_ff @(posedge clk) begin
            if (r_en) begin
                r_s1_data <= w_rd_word;
            end
        end

        // Stage 1 valid flag. Reset flushes it, so in-flight reads vanish.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1_vld <= 1'b0;
            end else begin
                r_s1_vld <= r_en;
            end
        end

        // Output stage: it only updates when stage 1 holds a live read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_dout <= r_s1_data;
                end
            end
        end
    end

    assign data_out = r_dout;
    assign r_valid  = r_vld;

endmodule

// File: tb/tb_iob_2p_mem_be.sv
// Directed bench for iob_2p_mem_be. Four instances share one stimulus stream
// and cover every RD_LAT x BYPASS combination:
//   0: RD_LAT=1 BYPASS=1   1: RD_LAT=1 BYPASS=0
//   2: RD_LAT=2 BYPASS=1   3: RD_LAT=2 BYPASS=0
module tb_iob_2p_mem_be;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        w_en = 1'b0;
    logic [3:0]  w_strb = '0;
    logic [5:0]  w_addr = '0;
    logic [31:0] data_in = '0;
    logic        r_en = 1'b0;
    logic [5:0]  r_addr = '0;
    logic [31:0] dout [4];
    logic        vld  [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        iob_2p_mem_be #(
            .DATA_W(32),
            .ADDR_W(6),
            .RD_LAT((gi < 2) ? 1 : 2),
            .BYPASS((gi % 2 == 0) ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .w_en(w_en),
            .w_strb(w_strb),
            .w_addr(w_addr),
            .data_in(data_in),
            .r_en(r_en),
            .r_addr(r_addr),
            .data_out(dout[gi]),
            .r_valid(vld[gi])
        );
    end

    function automatic int lat_of(input int i);
        return (i < 2) ? 1 : 2;
    endfunction

    function automatic bit byp_of(input int i);
        return (i % 2 == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input string tag, input int i, input bit exp_v,
                             input bit chk_d, input logic [31:0] exp_d);
        check($sformatf("%s[%0d]_valid", tag, i), {31'b0, vld[i]}, {31'b0, exp_v});
        if (chk_d) check($sformatf("%s[%0d]_data", tag, i), dout[i], exp_d);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        w_en = 1'b1; w_addr = a; data_in = d; w_strb = s;
        @(posedge clk); #1;
        w_en = 1'b0; w_strb = '0;
        $display("[TB] write addr=%0d data=%h strb=%b", a, d, s);
    endtask

    // Issue one read. Any write the caller has set up goes out on the same edge.
    // e_new is the result expected for BYPASS=1 instances; e_old for BYPASS=0.
    task automatic read_check(input string tag, input logic [5:0] a,
                              input logic [31:0] e_new, input logic [31:0] e_old);
        r_en = 1'b1; r_addr = a;
        @(posedge clk); #1;
        r_en = 1'b0; w_en = 1'b0; w_strb = '0;
        for (int i = 0; i < 4; i++) begin
            if (lat_of(i) == 1) check_dut({tag, "_e1"}, i, 1'b1, 1'b1, byp_of(i) ? e_new : e_old);
            else                check_dut({tag, "_e1"}, i, 1'b0, 1'b0, '0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (lat_of(i) == 2) check_dut({tag, "_e2"}, i, 1'b1, 1'b1, byp_of(i) ? e_new : e_old);
            else                check_dut({tag, "_e2"}, i, 1'b0, 1'b1, byp_of(i) ? e_new : e_old);
        end
        $display("[TB] read %s addr=%0d expect new=%h old=%h", tag, a, e_new, e_old);
    endtask

    // Stop a runaway simulation.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_dut("reset", i, 1'b0, 1'b1, 32'h0);
        rst = 1'b0;
        $display("[TB] reset released");

        // Fill all 64 words, then read them back-to-back
        for (int k = 0; k < 64; k++) do_write(k[5:0], 32'hA5000000 + k, 4'hF);
        for (int k = 0; k <= 65; k++) begin
            r_en = (k < 64); r_addr = k[5:0];
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                int idx;
                idx = k - (lat_of(i) - 1);
                if (idx >= 0 && idx < 64) check_dut("b2b", i, 1'b1, 1'b1, 32'hA5000000 + idx);
                else                      check_dut("b2b", i, 1'b0, 1'b0, '0);
            end
            if (k < 64) $display("[TB] b2b read addr=%0d", k);
        end
        r_en = 1'b0;

        // Byte strobes
        do_write(6'd5, 32'h11223344, 4'hF);
        do_write(6'd5, 32'hAABBCCDD, 4'b0101);
        read_check("strobe", 6'd5, 32'h11BB33DD, 32'h11BB33DD);

        // Collision at addr 9 on the same edge
        do_write(6'd9, 32'h00000000, 4'hF);
        w_en = 1'b1; w_addr = 6'd9; data_in = 32'hDEADBEEF; w_strb = 4'b0011;
        read_check("collide", 6'd9, 32'h0000BEEF, 32'h00000000);
        read_check("collide_after", 6'd9, 32'h0000BEEF, 32'h0000BEEF);

        // A write on the edge after issue must not reach a latency-2 read; data then holds
        do_write(6'd3, 32'h12345678, 4'hF);
        r_en = 1'b1; r_addr = 6'd3;
        @(posedge clk); #1;
        r_en = 1'b0;
        w_en = 1'b1; w_addr = 6'd3; data_in = 32'h0; w_strb = 4'hF;
        for (int i = 0; i < 4; i++) check_dut("hold_e1", i, lat_of(i) == 1, lat_of(i) == 1, 32'h12345678);
        @(posedge clk); #1;
        w_en = 1'b0; w_strb = '0;
        for (int i = 0; i < 4; i++) check_dut("hold_e2", i, lat_of(i) == 2, 1'b1, 32'h12345678);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) check_dut("hold_idle", i, 1'b0, 1'b1, 32'h12345678);
        end
        $display("[TB] read addr=3 with late write, held 5 idle cycles");

        // Reset mid-read. Writes during reset must be ignored.
        do_write(6'd7, 32'hCAFEF00D, 4'hF);
        r_en = 1'b1; r_addr = 6'd7;
        @(posedge clk); #1;
        r_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check_dut("rst_async", i, 1'b0, 1'b1, 32'h0);
        w_en = 1'b1; w_addr = 6'd7; data_in = 32'h0; w_strb = 4'hF;
        @(posedge clk); #1;
        w_en = 1'b0; w_strb = '0;
        for (int i = 0; i < 4; i++) check_dut("rst_hold", i, 1'b0, 1'b1, 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) check_dut("rst_after", i, 1'b0, 1'b1, 32'h0);
        end
        $display("[TB] reset during read, no late valid");
        read_check("rst_keep", 6'd7, 32'hCAFEF00D, 32'hCAFEF00D);

        // Independent ports: write addr 32+i while reading addr 32+i-1
        for (int k = 0; k <= 21; k++) begin
            w_en = (k < 20); w_addr = 6'(32 + k); data_in = 32'h5A5A0000 + k; w_strb = 4'hF;
            r_en = (k >= 1 && k <= 20); r_addr = 6'(32 + k - 1);
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                int idx;
                idx = k - lat_of(i);
                if (idx >= 0 && idx < 20) check_dut("indep", i, 1'b1, 1'b1, 32'h5A5A0000 + idx);
                else                      check_dut("indep", i, 1'b0, 1'b0, '0);
            end
            $display("[TB] indep cycle %0d w_en=%0b r_en=%0b", k, w_en, r_en);
        end
        w_en = 1'b0; r_en = 1'b0; w_strb = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
